// File: rtl/mode_sequencer.sv
// Mode controller: debounced mode/backspace buttons, NUM_MODES-way cycling, timed engine
// clear and gated backspace. Define MODE_SEQ_LONGPRESS_EN for release-advance plus long-press-to-0.
module mode_sequencer #(
  parameter int NUM_MODES       = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CLEAR_CYCLES    = 4,
  parameter int LONG_CYCLES     = 50000000,
  localparam int MODE_W         = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mode_btn_i,
  input  logic                 bs_btn_i,
  input  logic                 lock_i,
  output logic [MODE_W-1:0]    mode_o,
  output logic [NUM_MODES-1:0] mode_onehot_o,
  output logic                 mode_changed_o,
  output logic                 eng_rst_o,
  output logic                 bs_pulse_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLEAR_CYCLES);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam int BTN_MODE = 0;
  localparam int BTN_BS   = 1;

  generate
    if (NUM_MODES < 2 || NUM_MODES > 16 || DEBOUNCE_CYCLES < 2 ||
        CLEAR_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
      $error("mode_sequencer: parameter out of legal range");
    end
  endgenerate

  function automatic logic [NUM_MODES-1:0] onehot_of(input logic [MODE_W-1:0] idx);
    logic [NUM_MODES-1:0] vec;
    for (int k = 0; k < NUM_MODES; k++) begin
      vec[k] = (idx == MODE_W'(k));
    end
    return vec;
  endfunction

  logic [1:0]                 sync1_q, sync2_q;
  logic [1:0]                 stable_q, stable_d, stable_prev_q;
  logic [1:0][DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic [MODE_W-1:0]          mode_q, mode_d;
  logic [NUM_MODES-1:0]       onehot_q, onehot_d;
  logic                       changed_q, changed_d;
  logic [CLR_W-1:0]           clr_cnt_q, clr_cnt_d;
  logic                       eng_rst_q, eng_rst_d;
  logic                       bs_pulse_q, bs_pulse_d;
  logic                       bs_rise_s, adv_s, jump_s;

  // Per-button debounce: stable value flips after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
          db_cnt_d[i] = {DB_W{1'b0}};
        end else begin
          stable_d[i] = stable_q[i];
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        stable_d[i] = stable_q[i];
        db_cnt_d[i] = {DB_W{1'b0}};
      end
    end
  end

  assign bs_rise_s = stable_q[BTN_BS] & ~stable_prev_q[BTN_BS];

`ifdef MODE_SEQ_LONGPRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_hit_q, long_hit_d;
  logic              mode_fall_s;

  assign mode_fall_s = ~stable_q[BTN_MODE] & stable_prev_q[BTN_MODE];

  // Long-press timer; long_hit remembers the jump so the following release is not an advance
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_hit_d = long_hit_q;
    adv_s      = 1'b0;
    jump_s     = 1'b0;
    if (stable_q[BTN_MODE]) begin
      if (long_hit_q) begin
        long_cnt_d = long_cnt_q;
      end else if (long_cnt_q == LONG_LAST) begin
        long_hit_d = 1'b1;
        long_cnt_d = {LONG_W{1'b0}};
        jump_s     = ~lock_i;
      end else begin
        long_cnt_d = long_cnt_q + 1'b1;
      end
    end else begin
      long_cnt_d = {LONG_W{1'b0}};
      long_hit_d = 1'b0;
      adv_s      = mode_fall_s & ~long_hit_q & ~lock_i;
    end
  end

  // Long-press state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      long_cnt_q <= {LONG_W{1'b0}};
      long_hit_q <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_hit_q <= long_hit_d;
    end
  end
`else
  logic mode_rise_s;

  assign mode_rise_s = stable_q[BTN_MODE] & ~stable_prev_q[BTN_MODE];
  assign adv_s       = mode_rise_s & ~lock_i;
  assign jump_s      = 1'b0;
`endif

  // Mode advance, clear window and gated backspace; eng_rst covers the change cycle itself
  always_comb begin
    mode_d    = mode_q;
    changed_d = 1'b0;
    if (jump_s) begin
      mode_d    = {MODE_W{1'b0}};
      changed_d = 1'b1;
    end else if (adv_s) begin
      changed_d = 1'b1;
      if (mode_q == MODE_LAST) begin
        mode_d = {MODE_W{1'b0}};
      end else begin
        mode_d = mode_q + 1'b1;
      end
    end else begin
      mode_d = mode_q;
    end
    onehot_d = onehot_of(mode_d);
    if (changed_d) begin
      clr_cnt_d = CLR_LOAD;
    end else if (clr_cnt_q != {CLR_W{1'b0}}) begin
      clr_cnt_d = clr_cnt_q - 1'b1;
    end else begin
      clr_cnt_d = clr_cnt_q;
    end
    eng_rst_d  = (clr_cnt_d != {CLR_W{1'b0}});
    bs_pulse_d = bs_rise_s & ~eng_rst_d & ~changed_d;
  end

  // All sequencer state; reset aborts debounce and restarts the clear window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q       <= 2'b00;
      sync2_q       <= 2'b00;
      stable_q      <= 2'b00;
      stable_prev_q <= 2'b00;
      db_cnt_q      <= {(2 * DB_W){1'b0}};
      mode_q        <= {MODE_W{1'b0}};
      onehot_q      <= onehot_of({MODE_W{1'b0}});
      changed_q     <= 1'b0;
      clr_cnt_q     <= CLR_LOAD;
      eng_rst_q     <= 1'b1;
      bs_pulse_q    <= 1'b0;
    end else begin
      sync1_q       <= {bs_btn_i, mode_btn_i};
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
      mode_q        <= mode_d;
      onehot_q      <= onehot_d;
      changed_q     <= changed_d;
      clr_cnt_q     <= clr_cnt_d;
      eng_rst_q     <= eng_rst_d;
      bs_pulse_q    <= bs_pulse_d;
    end
  end

  assign mode_o         = mode_q;
  assign mode_onehot_o  = onehot_q;
  assign mode_changed_o = changed_q;
  assign eng_rst_o      = eng_rst_q;
  assign bs_pulse_o     = bs_pulse_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed self-checking bench for mode_sequencer (NUM_MODES=3, DEBOUNCE=4, CLEAR=2, LONG=16).
// Step k means the k-th falling clock edge after the stimulus was applied at step 0.
module tb_mode_sequencer;

  localparam int NUM_MODES       = 3;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CLEAR_CYCLES    = 2;
  localparam int LONG_CYCLES     = 16;

`ifdef MODE_SEQ_LONGPRESS_EN
  // 9-step press: release at step 9 -> stable fall at edge 15 -> advance at step 16
  localparam int ADV_IDX   = 16;
  localparam int BS_ON     = 9;
  localparam int HOLD_IDX  = 22;  // stable rise at edge 6, 16 stable-high cycles later
  localparam int SHORT_IDX = 13;  // release at step 6 -> stable fall at edge 12
`else
  localparam int ADV_IDX   = 7;
  localparam int BS_ON     = 0;
  localparam int HOLD_IDX  = 7;
  localparam int SHORT_IDX = 7;
`endif

  logic       clk = 1'b0;
  logic       rst, mode_btn, bs_btn, lock;
  logic [1:0] mode;
  logic [2:0] mode_onehot;
  logic       mode_changed, eng_rst, bs_pulse;

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] exp_mode;

  always #5 clk = ~clk;

  mode_sequencer #(
    .NUM_MODES(NUM_MODES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES), .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_btn_i(mode_btn), .bs_btn_i(bs_btn), .lock_i(lock),
    .mode_o(mode), .mode_onehot_o(mode_onehot), .mode_changed_o(mode_changed),
    .eng_rst_o(eng_rst), .bs_pulse_o(bs_pulse)
  );

  task automatic test_reset();
    logic exp_eng;
    rst = 1'b1; mode_btn = 1'b0; bs_btn = 1'b0; lock = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if (mode_onehot !== 3'b001) begin failures++; $display("FAIL reset_onehot got=%b exp=001", mode_onehot); end
    checks++; if (eng_rst !== 1'b1) begin failures++; $display("FAIL reset_eng_rst_during got=%b exp=1", eng_rst); end
    checks++; if (mode_changed !== 1'b0) begin failures++; $display("FAIL reset_mode_changed got=%b exp=0", mode_changed); end
    checks++; if (bs_pulse !== 1'b0) begin failures++; $display("FAIL reset_bs_pulse got=%b exp=0", bs_pulse); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_eng = (k < 2);
      checks++; if (eng_rst !== exp_eng) begin failures++; $display("FAIL reset_eng_rst_after k=%0d got=%b exp=%b", k, eng_rst, exp_eng); end
    end
    exp_mode = 2'd0;
  endtask

  task automatic test_mode_cycle();
    logic [5:0] seq;
    logic [1:0] old_mode, new_mode;
    logic       exp_chg, exp_eng;
    seq = {2'd0, 2'd2, 2'd1};
    for (int p = 0; p < 3; p++) begin
      old_mode = exp_mode;
      new_mode = seq[2*p +: 2];
      mode_btn = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        exp_mode = (k >= ADV_IDX) ? new_mode : old_mode;
        exp_chg  = (k == ADV_IDX);
        exp_eng  = (k == ADV_IDX) || (k == ADV_IDX + 1);
        checks++; if (mode_changed !== exp_chg) begin failures++; $display("FAIL cycle_changed p=%0d k=%0d got=%b exp=%b", p, k, mode_changed, exp_chg); end
        checks++; if (mode !== exp_mode) begin failures++; $display("FAIL cycle_mode p=%0d k=%0d got=%0d exp=%0d", p, k, mode, exp_mode); end
        checks++; if (eng_rst !== exp_eng) begin failures++; $display("FAIL cycle_eng_rst p=%0d k=%0d got=%b exp=%b", p, k, eng_rst, exp_eng); end
        checks++; if (mode_onehot !== (3'b001 << exp_mode)) begin failures++; $display("FAIL cycle_onehot p=%0d k=%0d got=%b exp=%b", p, k, mode_onehot, 3'b001 << exp_mode); end
        if (k == 9) mode_btn = 1'b0;
      end
    end
  endtask

  task automatic test_glitch();
    mode_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++; if (mode_changed !== 1'b0) begin failures++; $display("FAIL glitch_changed k=%0d got=%b exp=0", k, mode_changed); end
      checks++; if (mode !== exp_mode) begin failures++; $display("FAIL glitch_mode k=%0d got=%0d exp=%0d", k, mode, exp_mode); end
      checks++; if (eng_rst !== 1'b0) begin failures++; $display("FAIL glitch_eng_rst k=%0d got=%b exp=0", k, eng_rst); end
      if (k == 3) mode_btn = 1'b0;
    end
  endtask

  task automatic test_lock();
    logic [1:0] old_mode;
    logic       exp_chg;
    lock = 1'b1;
    mode_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++; if (mode_changed !== 1'b0) begin failures++; $display("FAIL lock_changed k=%0d got=%b exp=0", k, mode_changed); end
      checks++; if (mode !== exp_mode) begin failures++; $display("FAIL lock_mode k=%0d got=%0d exp=%0d", k, mode, exp_mode); end
      if (k == 9) mode_btn = 1'b0;
    end
    lock = 1'b0;
    old_mode = exp_mode;
    mode_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_mode = (k >= ADV_IDX) ? ((old_mode == 2'd2) ? 2'd0 : old_mode + 2'd1) : old_mode;
      exp_chg  = (k == ADV_IDX);
      checks++; if (mode_changed !== exp_chg) begin failures++; $display("FAIL unlock_changed k=%0d got=%b exp=%b", k, mode_changed, exp_chg); end
      checks++; if (mode !== exp_mode) begin failures++; $display("FAIL unlock_mode k=%0d got=%0d exp=%0d", k, mode, exp_mode); end
      if (k == 9) mode_btn = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] old_mode;
    logic       exp_chg;
    old_mode = exp_mode;
    mode_btn = 1'b1;
    bs_btn   = (BS_ON == 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_mode = (k >= ADV_IDX) ? ((old_mode == 2'd2) ? 2'd0 : old_mode + 2'd1) : old_mode;
      exp_chg  = (k == ADV_IDX);
      checks++; if (bs_pulse !== 1'b0) begin failures++; $display("FAIL simul_bs_pulse k=%0d got=%b exp=0", k, bs_pulse); end
      checks++; if (mode_changed !== exp_chg) begin failures++; $display("FAIL simul_changed k=%0d got=%b exp=%b", k, mode_changed, exp_chg); end
      checks++; if (mode !== exp_mode) begin failures++; $display("FAIL simul_mode k=%0d got=%0d exp=%0d", k, mode, exp_mode); end
      if (k == 9) mode_btn = 1'b0;
      bs_btn = (k >= BS_ON) && (k < BS_ON + 9);
    end
  endtask

  task automatic test_backspace();
    logic exp_bs;
    bs_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_bs = (k == 7);
      checks++; if (bs_pulse !== exp_bs) begin failures++; $display("FAIL bs_pulse k=%0d got=%b exp=%b", k, bs_pulse, exp_bs); end
      checks++; if (mode_changed !== 1'b0) begin failures++; $display("FAIL bs_changed k=%0d got=%b exp=0", k, mode_changed); end
      if (k == 9) bs_btn = 1'b0;
    end
  endtask

  task automatic test_long_hold();
    logic [1:0] old_mode;
    logic       exp_chg, exp_eng;
    old_mode = exp_mode;
    mode_btn = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      exp_mode = (k >= HOLD_IDX) ? 2'd0 : old_mode;
      exp_chg  = (k == HOLD_IDX);
      exp_eng  = (k == HOLD_IDX) || (k == HOLD_IDX + 1);
      checks++; if (mode_changed !== exp_chg) begin failures++; $display("FAIL hold_changed k=%0d got=%b exp=%b", k, mode_changed, exp_chg); end
      checks++; if (mode !== exp_mode) begin failures++; $display("FAIL hold_mode k=%0d got=%0d exp=%0d", k, mode, exp_mode); end
      checks++; if (eng_rst !== exp_eng) begin failures++; $display("FAIL hold_eng_rst k=%0d got=%b exp=%b", k, eng_rst, exp_eng); end
      if (k == 30) mode_btn = 1'b0;
    end
  endtask

  task automatic test_short_press();
    logic exp_chg;
    mode_btn = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      exp_mode = (k >= SHORT_IDX) ? 2'd1 : 2'd0;
      exp_chg  = (k == SHORT_IDX);
      checks++; if (mode_changed !== exp_chg) begin failures++; $display("FAIL short_changed k=%0d got=%b exp=%b", k, mode_changed, exp_chg); end
      checks++; if (mode !== exp_mode) begin failures++; $display("FAIL short_mode k=%0d got=%0d exp=%0d", k, mode, exp_mode); end
      if (k == 6) mode_btn = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();     // 1, 2, 0
    test_glitch();
    test_lock();           // -> 1
    test_simultaneous();   // -> 2
    test_backspace();
    test_long_hold();      // from 2 -> 0
    test_short_press();    // -> 1
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Parametrised mode controller for the Morse encoder/decoder top level. It debounces the mode and backspace push-buttons internally and cycles through NUM_MODES operating modes instead of a single toggle bit. It drives a one-hot mode-select bus and a timed engine-clear pulse so the engine being left is flushed. It gates backspace events so they never reach an engine that is being cleared.

## Interface
Parameters:
- NUM_MODES, 2: number of modes; legal range 2..16.
- DEBOUNCE_CYCLES, 20000: consecutive clk cycles a synchronised input must differ from its stable value before the stable value changes; minimum 2.
- CLEAR_CYCLES, 4: length in cycles of eng_rst after a mode change or reset; minimum 1.
- LONG_CYCLES, 50000000: stable-high duration of the mode button that counts as a long press. Used only with MODE_SEQ_LONGPRESS_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- mode_btn  in  1  raw mode push-button, asynchronous.
- bs_btn  in  1  raw backspace push-button, asynchronous.
- lock  in  1  when high, mode-change requests are ignored (for example during playback).
- mode  out  MODE_W  current mode index, where MODE_W = max(1, clog2(NUM_MODES)).
- mode_onehot  out  NUM_MODES  one-hot decode of mode, registered.
- mode_changed  out  1  single-cycle pulse in the cycle mode takes a new value.
- eng_rst  out  1  engine-clear request for the downstream encoder/decoder.
- bs_pulse  out  1  single-cycle debounced backspace event.

## Operation
- **Synchronisers.** Each button passes through a 2-flop synchroniser.
- **Debouncer (per button).**
  - A counter increments while the synchronised value differs from the stable value.
  - The counter clears on any cycle where they agree.
  - When the count reaches DEBOUNCE_CYCLES, the stable value flips and the counter clears.
- **Mode advance.**
  - Compute next = (mode == NUM_MODES-1) ? 0 : mode+1.
  - The mode register, mode_onehot and mode_changed update together.
- **Advance trigger (default build).** A rising edge of stable mode_btn while lock=0. With lock=1 the edge is discarded, not queued.
- **Engine clear.**
  - Any mode change loads the clear counter with CLEAR_CYCLES.
  - eng_rst = (counter != 0).
  - A change during an active window reloads the counter, so the window restarts.
- **Backspace.**
  - A rising edge of stable bs_btn produces bs_pulse.
  - bs_pulse is suppressed if eng_rst is high or mode_changed is high in that cycle. The event is dropped, not deferred.
- **Reset.**
  - mode=0, mode_onehot=1, mode_changed=0, bs_pulse=0.
  - All debounce and stable state cleared, so buttons read as released.
  - The clear counter is loaded with CLEAR_CYCLES, so eng_rst=1 during rst and for CLEAR_CYCLES cycles after its release.
  - Reset mid-debounce or mid-window aborts that activity.

## Timing
- Raw edge to stable flip: 2 synchroniser cycles plus DEBOUNCE_CYCLES cycles.
- Mode change occurs in the cycle after the stable flip, at the edge detect. mode_changed is high in that same cycle, and eng_rst rises in that same cycle.
- eng_rst is high for exactly CLEAR_CYCLES cycles starting with the mode_changed cycle, unless reloaded.
- bs_pulse is asserted in the cycle after the stable bs_btn flip.
- Simultaneous mode and backspace events: the mode change wins and bs_pulse is dropped.
- Glitches shorter than DEBOUNCE_CYCLES never alter stable state.

## Configuration
- MODE_SEQ_LONGPRESS_EN defined:
  - A short press, released before LONG_CYCLES, advances the mode on the release edge.
  - A press held for LONG_CYCLES stable-high cycles jumps to mode 0 in that cycle, with mode_changed and eng_rst as for a normal change. This applies even if mode is already 0, to re-clear the engine.
  - The following release causes no advance.
  - lock=1 suppresses both the short-press advance and the long-press jump.
- MODE_SEQ_LONGPRESS_EN undefined:
  - Advance happens on the press edge.
  - No long-press counter is built and LONG_CYCLES is ignored.

## Test plan
Bench parameters: NUM_MODES=3, DEBOUNCE_CYCLES=4, CLEAR_CYCLES=2, LONG_CYCLES=16.
- Reset held 3 cycles, then released -> mode=0, mode_onehot=3'b001, eng_rst=1 during reset and for 2 cycles after.
- Three clean mode presses -> mode goes 1, 2, 0 (wrap). mode_changed pulses once per press, 7 cycles after each raw edge. eng_rst is high for 2 cycles each time.
- A 3-cycle glitch on mode_btn -> no mode change, no pulses.
- A mode press with lock=1 -> mode unchanged. A later press with lock=0 -> a single advance.
- Backspace and mode edges whose stable flips land on the same cycle -> mode advances and bs_pulse stays 0. An isolated backspace press -> one bs_pulse.
- With MODE_SEQ_LONGPRESS_EN, starting from mode=2:
  - Hold mode_btn for 30 cycles -> mode=0 at stable-high cycle 16, and no advance on release.
  - A 6-cycle press -> advance to 1 on release.
